// File: rtl/ram_stream_reader.sv
// Streams a burst of words from a synchronous 1R/1W RAM into a valid/ready port.
// Reads are issued only when the small 2-entry FIFO has room for every word still in flight.
module ram_stream_reader #(
  parameter int width_p = 8,
  parameter int depth_p = 128,
  localparam int aw = $clog2(depth_p)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic [aw-1:0]      base_addr_i,
  input  logic [aw:0]        len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [aw-1:0]      rd_addr_o,
  input  logic               wr_block_i,
  input  logic [width_p-1:0] rd_data_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [aw-1:0] last_addr = aw'(depth_p - 1);
  localparam logic [aw-1:0] one_addr  = aw'(1);
  localparam logic [aw:0]   one_len   = (aw + 1)'(1);

  state_t state, state_next;

  logic [aw-1:0]      rd_addr;
  logic [aw:0]        issue_left;
  logic               inflight;
  logic               done;
  logic [width_p-1:0] fifo [0:1];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic [1:0]         outstanding;

  logic accept, accept_empty, pop, credit, issue, last_pop, head_valid;

  assign head_valid   = (count != 2'd0);
  assign accept       = (state == IDLE) && start_i && (len_i != '0);
  assign accept_empty = (state == IDLE) && start_i && (len_i == '0);
  assign pop          = head_valid && ready_i;
  // Words already in the FIFO plus the one read in flight must never exceed two slots.
  assign outstanding  = count + {1'b0, inflight};
  assign credit       = (outstanding <= 2'd1) || ((outstanding == 2'd2) && pop);
  assign issue        = (state == RUN) && !wr_block_i && credit;
  assign last_pop     = (state == DRAIN) && pop && !inflight && (count == 2'd1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (issue && (issue_left == one_len)) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state != IDLE);
    valid_o   = head_valid;
    data_o    = head_valid ? fifo[rd_ptr] : '0;
    rd_addr_o = rd_addr;
    done_o    = done;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_addr    <= '0;
      issue_left <= '0;
      inflight   <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= accept_empty || last_pop;
      if (accept) begin
        rd_addr    <= base_addr_i;
        issue_left <= len_i;
      end else if (issue) begin
        rd_addr    <= (rd_addr == last_addr) ? '0 : rd_addr + one_addr;
        issue_left <= issue_left - one_len;
      end
    end
  end

  // RAM data for a read appears one edge after the issue, so the in-flight flag is the push strobe.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fifo[0] <= '0;
      fifo[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (inflight) begin
        fifo[wr_ptr] <= rd_data_i;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a RAM model holding RAM[i] = i.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_stream_reader;

  localparam int width_p = 8;
  localparam int depth_p = 128;
  localparam int aw      = 7;

  logic               clk_i = 1'b0;
  logic               reset_ni;
  logic               start_i;
  logic [aw-1:0]      base_addr_i;
  logic [aw:0]        len_i;
  logic               busy_o;
  logic               done_o;
  logic [aw-1:0]      rd_addr_o;
  logic               wr_block_i;
  logic [width_p-1:0] rd_data_i;
  logic [width_p-1:0] data_o;
  logic               valid_o;
  logic               ready_i;

  int checks = 0;
  int errors = 0;

  logic [width_p-1:0] got [$];
  logic [aw-1:0]      addr_log [$];
  int                 first_valid, done_cyc, max_out, issued;
  logic               done_seen, aborted;

  ram_stream_reader #(.width_p(width_p), .depth_p(depth_p)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o),
    .done_o(done_o), .rd_addr_o(rd_addr_o), .wr_block_i(wr_block_i),
    .rd_data_i(rd_data_i), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (!wr_block_i) rd_data_i <= {1'b0, rd_addr_o};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Runs one burst, logging issued addresses and transferred words until done_o, abort or budget.
  task automatic applyStimulus(input logic [aw-1:0] base, input logic [aw:0] len, input int ready_pct,
                               input int block_at, input int block_n, input int restart_at,
                               input int reset_after, input int budget);
    int                 cyc;
    logic               stalled, blk_prev;
    logic [width_p-1:0] held;
    logic [aw-1:0]      prev_addr;
    got.delete();
    addr_log.delete();
    first_valid = -1; done_cyc = -1; max_out = 0; issued = 0;
    done_seen = 1'b0; aborted = 1'b0;
    stalled = 1'b0; blk_prev = 1'b0; held = '0; cyc = 0;
    start_i = 1'b1; base_addr_i = base; len_i = len;
    @(negedge clk_i);
    start_i = 1'b0;
    prev_addr = rd_addr_o;
    if (len != 0) checkOutput("addr_load", rd_addr_o, base);
    while (!done_seen && !aborted && cyc < budget) begin
      if (reset_after >= 0 && got.size() == reset_after) begin
        reset_ni = 1'b0;
        #1;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_addr", rd_addr_o, 0);
        checkOutput("rst_data", data_o, 0);
        aborted = 1'b1;
      end else begin
        if (stalled) begin
          checkOutput("stall_valid", valid_o, 1);
          checkOutput("stall_data", data_o, held);
        end
        if (blk_prev) checkOutput("blk_hold", rd_addr_o, prev_addr);
        if (rd_addr_o != prev_addr) begin
          issued++;
          addr_log.push_back(prev_addr);
        end
        prev_addr = rd_addr_o;
        if (issued - int'(got.size()) > max_out) max_out = issued - int'(got.size());
        if (valid_o && first_valid < 0) first_valid = cyc;
        if (done_o) begin
          done_seen = 1'b1;
          done_cyc  = cyc;
          checkOutput("done_idle", {busy_o, valid_o}, 0);
        end
        start_i = (cyc == restart_at);
        if (start_i) begin
          base_addr_i = 7'd50;
          len_i       = 8'd7;
        end
        wr_block_i = (cyc >= block_at) && (cyc < block_at + block_n);
        blk_prev   = wr_block_i;
        ready_i    = ($urandom_range(0, 99) < ready_pct);
        if (valid_o && ready_i) got.push_back(data_o);
        stalled = valid_o && !ready_i;
        held    = data_o;
        @(negedge clk_i);
        cyc++;
      end
    end
    start_i = 1'b0;
    wr_block_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic checkBurst(input logic [aw-1:0] base, input int len);
    checkOutput("done_seen", done_seen, 1);
    checkOutput("word_count", got.size(), len);
    checkOutput("issue_count", issued, len);
    for (int k = 0; k < got.size() && k < len; k++)
      checkOutput($sformatf("word%0d", k), got[k], (int'(base) + k) % depth_p);
    for (int k = 0; k < addr_log.size() && k < len; k++)
      checkOutput($sformatf("addr%0d", k), addr_log[k], (int'(base) + k) % depth_p);
    checkOutput("occupancy", max_out <= 2, 1);
    @(negedge clk_i);
    checkOutput("done_once", done_o, 0);
  endtask

  initial begin
    reset_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    wr_block_i = 1'b0; ready_i = 1'b1;
    #12;
    checkOutput("reset_valid", valid_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_addr", rd_addr_o, 0);
    checkOutput("reset_data", data_o, 0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    $display("[TB] basic burst base=4 len=5");
    applyStimulus(7'd4, 8'd5, 100, -1, 0, -1, -1, 50);
    checkOutput("first_valid", first_valid, 2);
    checkOutput("done_cycle", done_cyc, 7);
    checkBurst(7'd4, 5);

    $display("[TB] wrap base=126 len=4");
    applyStimulus(7'd126, 8'd4, 100, -1, 0, -1, -1, 50);
    checkBurst(7'd126, 4);

    $display("[TB] backpressure len=20");
    applyStimulus(7'd60, 8'd20, 50, -1, 0, -1, -1, 300);
    checkBurst(7'd60, 20);

    $display("[TB] write block mid-burst");
    applyStimulus(7'd30, 8'd10, 100, 3, 3, -1, -1, 60);
    checkBurst(7'd30, 10);

    $display("[TB] zero length");
    applyStimulus(7'd90, 8'd0, 100, -1, 0, -1, -1, 20);
    checkOutput("z_done", done_seen, 1);
    checkOutput("z_done_cycle", done_cyc, 0);
    checkOutput("z_no_valid", first_valid, -1);
    checkOutput("z_no_issue", issued, 0);
    checkOutput("z_no_words", got.size(), 0);
    @(negedge clk_i);
    checkOutput("z_done_once", done_o, 0);

    $display("[TB] start ignored while running");
    applyStimulus(7'd10, 8'd3, 100, -1, 0, 1, -1, 50);
    checkBurst(7'd10, 3);

    $display("[TB] reset mid-burst");
    applyStimulus(7'd20, 8'd10, 100, -1, 0, -1, 3, 50);
    checkOutput("aborted", aborted, 1);
    @(negedge clk_i);
    checkOutput("rst_hold_valid", valid_o, 0);
    checkOutput("rst_hold_done", done_o, 0);
    reset_ni = 1'b1;
    applyStimulus(7'd40, 8'd6, 100, -1, 0, -1, -1, 50);
    checkOutput("post_rst_first_valid", first_valid, 2);
    checkBurst(7'd40, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter width_p, default 8, data word width in bits.
REQ-002 SHALL have parameter depth_p, default 128, number of words in the attached 1-read/1-write synchronous RAM; aw = $clog2(depth_p).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr_i  input  aw  first RAM address of burst.
REQ-007 SHALL have port len_i  input  aw+1  number of words in burst, 0..depth_p.
REQ-008 SHALL have port busy_o  output  1  high whenever not IDLE.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port rd_addr_o  output  aw  read address driven to RAM.
REQ-011 SHALL have port wr_block_i  input  1  RAM write this cycle; RAM will not capture rd_addr_o at this edge.
REQ-012 SHALL have port rd_data_i  input  width_p  RAM read data for the address captured at the previous edge.
REQ-013 SHALL have port data_o  output  width_p  stream data.
REQ-014 SHALL have port valid_o  output  1  stream valid.
REQ-015 SHALL have port ready_i  input  1  stream ready; transfer when valid_o and ready_i.

Function
REQ-016 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start_i with len_i>0; RUN->DRAIN when last read issued; DRAIN->IDLE when last word transferred.
REQ-017 SHALL, on start_i in IDLE with len_i==0, stay in IDLE, issue no reads and pulse done_o in the following cycle.
REQ-018 SHALL latch base_addr_i and len_i on the accepting edge; start_i and inputs SHALL be ignored outside IDLE.
REQ-019 SHALL count an issue in a RUN cycle when wr_block_i==0 and credit is available; a cycle with wr_block_i==1 SHALL NOT be counted and rd_addr_o SHALL hold.
REQ-020 SHALL drive rd_addr_o with the next address to issue; after each issue it advances by 1 modulo depth_p (depth_p-1 wraps to 0).
REQ-021 SHALL capture rd_data_i into a 2-entry FIFO exactly one cycle after each counted issue, never otherwise.
REQ-022 SHALL grant credit when FIFO occupancy + in-flight reads <= 1, or == 2 with a transfer occurring this cycle; occupancy+in-flight SHALL never exceed 2.
REQ-023 SHALL present FIFO head on data_o with valid_o = FIFO non-empty; data_o SHALL remain stable while valid_o && !ready_i.
REQ-024 SHALL sustain one word per cycle with ready_i high and wr_block_i low; first valid_o two cycles after the accepting edge.
REQ-025 SHALL deliver exactly len words in ascending (wrapping) address order, no drops or duplicates.
REQ-026 SHALL pulse done_o in the cycle after the last transfer, concurrent with return to IDLE; a new start_i is accepted on that same IDLE cycle.

Reset
REQ-027 SHALL, while reset_ni==0, asynchronously force state IDLE, FIFO empty, in-flight cleared, valid_o=0, busy_o=0, done_o=0, rd_addr_o=0, data_o=0.
REQ-028 SHALL abort any burst on reset mid-operation, with no done_o pulse and no residual words after release.
REQ-029 SHALL accept start_i on the first rising edge after reset_ni deasserts.

Verification
REQ-030 SHALL verify: RAM[i]=i, base=4, len=5, ready_i=1 -> data_o 4,5,6,7,8 on consecutive cycles, first valid 2 cycles after start, done_o once.
REQ-031 SHALL verify wrap: depth_p=128, base=126, len=4 -> rd_addr_o 126,127,0,1; data order matches.
REQ-032 SHALL verify backpressure: ready_i random 50% over len=20 -> 20 ordered words, data_o stable while stalled, occupancy<=2.
REQ-033 SHALL verify wr_block_i high for 3 cycles mid-burst -> rd_addr_o held, no capture, no gap in data sequence.
REQ-034 SHALL verify len=0 -> done_o pulse next cycle, valid_o never high; start_i during RUN ignored.
REQ-035 SHALL verify reset_ni low for 1 cycle after 3 of 10 words -> outputs zero immediately, no further valid_o, new burst after release correct.
